// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// Module   : cdb_arbiter_if
// Brief    : Producer-push and CDB-broadcast signal bundle for cdb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8
);
  logic                  RSCDB_en;
  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index;
  logic [31:0]           RSCDB_value;
  logic [ADDR_WIDTH-1:0] RSCDB_next_pc;
  logic                  CDBRS_full;

  logic                  LSBCDB_en;
  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index;
  logic [31:0]           LSBCDB_value;
  logic                  CDBLSB_full;

  logic                  CDB_en;
  logic [RoB_WIDTH-1:0]  CDB_RoB_index;
  logic [31:0]           CDB_value;
  logic [ADDR_WIDTH-1:0] CDB_next_pc;
  logic                  CDB_src;

  // Producer/consumer side of the bus.
  modport master (
    output RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
    output LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    input  CDBRS_full, CDBLSB_full,
    input  CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
  );

  // Arbiter side of the bus.
  modport slave (
    input  RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
    input  LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    output CDBRS_full, CDBLSB_full,
    output CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin common data bus arbiter between the RS (ALU) and the
//            LSB result FIFOs, with registered broadcast and mispredict flush.
//            Optional macro CDB_BYPASS_EN: a push into an empty FIFO that wins
//            arbitration goes straight to the CDB registers (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_WIDTH = 2
) (
  input  wire logic     Sys_clk,
  input  wire logic     Sys_rst,
  input  wire logic     Sys_rdy,
  input  wire logic     RoBCDB_pre_judge,
  cdb_arbiter_if.slave  bus
);

  localparam int c_FIFO_SIZE = 1 << FIFO_WIDTH;
  localparam int c_CNT_W     = FIFO_WIDTH + 1;
  localparam logic c_SRC_RS  = 1'b0;
  localparam logic c_SRC_LSB = 1'b1;

  // Per-producer FIFO storage
  logic [RoB_WIDTH-1:0]  r_rs_idx [c_FIFO_SIZE];
  logic [31:0]           r_rs_val [c_FIFO_SIZE];
  logic [ADDR_WIDTH-1:0] r_rs_npc [c_FIFO_SIZE];
  logic [RoB_WIDTH-1:0]  r_lsb_idx [c_FIFO_SIZE];
  logic [31:0]           r_lsb_val [c_FIFO_SIZE];

  logic [FIFO_WIDTH-1:0] r_rs_head, r_rs_tail;
  logic [FIFO_WIDTH-1:0] r_lsb_head, r_lsb_tail;
  logic [c_CNT_W-1:0]    r_rs_cnt, r_lsb_cnt;
  logic                  r_last_grant;

  logic                  r_cdb_en;
  logic [RoB_WIDTH-1:0]  r_cdb_idx;
  logic [31:0]           r_cdb_val;
  logic [ADDR_WIDTH-1:0] r_cdb_npc;
  logic                  r_cdb_src;

  logic w_rs_full, w_lsb_full;
  logic w_rs_ne, w_lsb_ne;
  logic w_rs_push_ok, w_lsb_push_ok;
  logic w_rs_cand, w_lsb_cand;
  logic w_grant_valid, w_grant_side;
  logic w_rs_pop, w_lsb_pop;
  logic w_rs_bypass, w_lsb_bypass;
  logic w_rs_wr, w_lsb_wr;
  logic w_clear, w_run;

  logic [RoB_WIDTH-1:0]  w_cdb_idx;
  logic [31:0]           w_cdb_val;
  logic [ADDR_WIDTH-1:0] w_cdb_npc;

  assign w_rs_full     = (r_rs_cnt  == c_CNT_W'(c_FIFO_SIZE));
  assign w_lsb_full    = (r_lsb_cnt == c_CNT_W'(c_FIFO_SIZE));
  assign w_rs_ne       = (r_rs_cnt  != '0);
  assign w_lsb_ne      = (r_lsb_cnt != '0);
  assign w_rs_push_ok  = bus.RSCDB_en  && !w_rs_full;
  assign w_lsb_push_ok = bus.LSBCDB_en && !w_lsb_full;

  assign w_clear = !Sys_rst || !RoBCDB_pre_judge;
  assign w_run   = !w_clear && Sys_rdy;

`ifdef CDB_BYPASS_EN
  // A live push competes as if it already sat at the head of its FIFO.
  assign w_rs_cand  = w_rs_ne  || w_rs_push_ok;
  assign w_lsb_cand = w_lsb_ne || w_lsb_push_ok;
`else
  assign w_rs_cand  = w_rs_ne;
  assign w_lsb_cand = w_lsb_ne;
`endif

  always_comb begin
    w_grant_valid = w_rs_cand || w_lsb_cand;
    w_grant_side  = c_SRC_RS;
    if (w_rs_cand && w_lsb_cand) begin
      w_grant_side = ~r_last_grant;
    end else if (w_lsb_cand) begin
      w_grant_side = c_SRC_LSB;
    end
  end

  // Bypass only arises when the winning side has nothing queued.
  assign w_rs_pop     = w_grant_valid && (w_grant_side == c_SRC_RS)  &&  w_rs_ne;
  assign w_lsb_pop    = w_grant_valid && (w_grant_side == c_SRC_LSB) &&  w_lsb_ne;
  assign w_rs_bypass  = w_grant_valid && (w_grant_side == c_SRC_RS)  && !w_rs_ne;
  assign w_lsb_bypass = w_grant_valid && (w_grant_side == c_SRC_LSB) && !w_lsb_ne;
  assign w_rs_wr      = w_rs_push_ok  && !w_rs_bypass;
  assign w_lsb_wr     = w_lsb_push_ok && !w_lsb_bypass;

  always_comb begin
    w_cdb_idx = '0;
    w_cdb_val = '0;
    w_cdb_npc = '0;
    if (w_grant_side == c_SRC_RS) begin
      if (w_rs_ne) begin
        w_cdb_idx = r_rs_idx[r_rs_head];
        w_cdb_val = r_rs_val[r_rs_head];
        w_cdb_npc = r_rs_npc[r_rs_head];
      end else begin
        w_cdb_idx = bus.RSCDB_RoB_index;
        w_cdb_val = bus.RSCDB_value;
        w_cdb_npc = bus.RSCDB_next_pc;
      end
    end else begin
      if (w_lsb_ne) begin
        w_cdb_idx = r_lsb_idx[r_lsb_head];
        w_cdb_val = r_lsb_val[r_lsb_head];
      end else begin
        w_cdb_idx = bus.LSBCDB_RoB_index;
        w_cdb_val = bus.LSBCDB_value;
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge Sys_clk) begin
    if (w_run && w_rs_wr) begin
      r_rs_idx[r_rs_tail] <= bus.RSCDB_RoB_index;
      r_rs_val[r_rs_tail] <= bus.RSCDB_value;
      r_rs_npc[r_rs_tail] <= bus.RSCDB_next_pc;
    end
    if (w_run && w_lsb_wr) begin
      r_lsb_idx[r_lsb_tail] <= bus.LSBCDB_RoB_index;
      r_lsb_val[r_lsb_tail] <= bus.LSBCDB_value;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (w_clear) begin
      r_rs_head    <= '0;
      r_rs_tail    <= '0;
      r_rs_cnt     <= '0;
      r_lsb_head   <= '0;
      r_lsb_tail   <= '0;
      r_lsb_cnt    <= '0;
      r_last_grant <= c_SRC_LSB;
      r_cdb_en     <= 1'b0;
      r_cdb_idx    <= '0;
      r_cdb_val    <= '0;
      r_cdb_npc    <= '0;
      r_cdb_src    <= 1'b0;
    end else if (Sys_rdy) begin
      if (w_rs_wr)   r_rs_tail  <= r_rs_tail + 1'b1;
      if (w_rs_pop)  r_rs_head  <= r_rs_head + 1'b1;
      if (w_lsb_wr)  r_lsb_tail <= r_lsb_tail + 1'b1;
      if (w_lsb_pop) r_lsb_head <= r_lsb_head + 1'b1;
      r_rs_cnt  <= r_rs_cnt  + c_CNT_W'(w_rs_wr)  - c_CNT_W'(w_rs_pop);
      r_lsb_cnt <= r_lsb_cnt + c_CNT_W'(w_lsb_wr) - c_CNT_W'(w_lsb_pop);
      if (w_grant_valid) begin
        r_cdb_en     <= 1'b1;
        r_cdb_idx    <= w_cdb_idx;
        r_cdb_val    <= w_cdb_val;
        r_cdb_npc    <= w_cdb_npc;
        r_cdb_src    <= w_grant_side;
        r_last_grant <= w_grant_side;
      end else begin
        r_cdb_en <= 1'b0;
      end
    end else begin
      r_cdb_en <= 1'b0;
    end
  end

  assign bus.CDBRS_full    = w_rs_full;
  assign bus.CDBLSB_full   = w_lsb_full;
  assign bus.CDB_en        = r_cdb_en;
  assign bus.CDB_RoB_index = r_cdb_idx;
  assign bus.CDB_value     = r_cdb_val;
  assign bus.CDB_next_pc   = r_cdb_npc;
  assign bus.CDB_src       = r_cdb_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter; per-source expectation queues
//            are filled by the stimulus and drained by a CDB monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
  localparam int c_LAT = 1;
`else
  localparam int c_LAT = 2;
`endif

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] val;
    logic [31:0] npc;
  } exp_t;

  logic Sys_clk;
  logic Sys_rst;
  logic Sys_rdy;
  logic RoBCDB_pre_judge;

  cdb_arbiter_if #(.ADDR_WIDTH(32), .RoB_WIDTH(8)) bus ();

  cdb_arbiter #(.ADDR_WIDTH(32), .RoB_WIDTH(8), .FIFO_WIDTH(2)) dut (
    .Sys_clk          (Sys_clk),
    .Sys_rst          (Sys_rst),
    .Sys_rdy          (Sys_rdy),
    .RoBCDB_pre_judge (RoBCDB_pre_judge),
    .bus              (bus)
  );

  exp_t rs_q[$];
  exp_t lsb_q[$];
  logic src_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every broadcast must match the head of its source queue.
  always @(negedge Sys_clk) begin
    if (bus.CDB_en === 1'b1) begin
      exp_t e;
      src_log.push_back(bus.CDB_src);
      if (bus.CDB_src == 1'b0) begin
        if (rs_q.size() == 0) check("rs_unexpected", {72'd0, bus.CDB_RoB_index}, 80'hFFFF);
        else begin
          e = rs_q.pop_front();
          check("rs_entry", {8'd0, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_next_pc},
                {8'd0, e.idx, e.val, e.npc});
        end
      end else begin
        if (lsb_q.size() == 0) check("lsb_unexpected", {72'd0, bus.CDB_RoB_index}, 80'hFFFF);
        else begin
          e = lsb_q.pop_front();
          check("lsb_entry", {8'd0, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_next_pc},
                {8'd0, e.idx, e.val, 32'd0});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic idle();
    bus.RSCDB_en  = 1'b0;
    bus.LSBCDB_en = 1'b0;
  endtask

  task automatic drive_rs(input logic [7:0] idx, input logic [31:0] val,
                          input logic [31:0] npc, input bit expect_it);
    exp_t e;
    bus.RSCDB_en        = 1'b1;
    bus.RSCDB_RoB_index = idx;
    bus.RSCDB_value     = val;
    bus.RSCDB_next_pc   = npc;
    if (expect_it) begin
      e.idx = idx; e.val = val; e.npc = npc;
      rs_q.push_back(e);
    end
  endtask

  task automatic drive_lsb(input logic [7:0] idx, input logic [31:0] val, input bit expect_it);
    exp_t e;
    bus.LSBCDB_en        = 1'b1;
    bus.LSBCDB_RoB_index = idx;
    bus.LSBCDB_value     = val;
    if (expect_it) begin
      e.idx = idx; e.val = val; e.npc = 32'd0;
      lsb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    idle();
    Sys_rst = 1'b0;
    tick();
    tick();
    Sys_rst = 1'b1;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    idle();
    while ((rs_q.size() + lsb_q.size()) != 0 && n < limit) begin
      tick();
      n++;
    end
    check(name, 80'(rs_q.size() + lsb_q.size()), 80'd0);
    tick();
    tick();
  endtask

  initial begin
    bit seen_full;
    bit done;
    int rs_n;
    int lsb_n;

    Sys_rst = 1'b0;
    Sys_rdy = 1'b1;
    RoBCDB_pre_judge = 1'b1;
    idle();
    bus.RSCDB_RoB_index  = '0;
    bus.RSCDB_value      = '0;
    bus.RSCDB_next_pc    = '0;
    bus.LSBCDB_RoB_index = '0;
    bus.LSBCDB_value     = '0;

    // 1: reset dominates a live push
    drive_rs(8'h11, 32'hDEAD, 32'h44, 1'b0);
    tick();
    tick();
    check("rst_cdb_en",   80'(bus.CDB_en), 80'd0);
    check("rst_rs_full",  80'(bus.CDBRS_full), 80'd0);
    check("rst_lsb_full", 80'(bus.CDBLSB_full), 80'd0);
    check("rst_fields",   {bus.CDB_RoB_index, bus.CDB_value, bus.CDB_next_pc, bus.CDB_src},
          80'd0);
    idle();
    Sys_rst = 1'b1;
    repeat (4) tick();
    check("post_rst_quiet", 80'(bus.CDB_en), 80'd0);

    // 2: single RS push, latency and one-cycle broadcast
    do_reset();
    drive_rs(8'd5, 32'h1234, 32'h80, 1'b1);
    tick();
    idle();
    check("lat_edge_n",  80'(bus.CDB_en), 80'(c_LAT == 1));
    tick();
    check("lat_edge_n1", 80'(bus.CDB_en), 80'(c_LAT == 2));
    tick();
    check("lat_one_cycle", 80'(bus.CDB_en), 80'd0);
    drain("drain_single", 10);

    // 3: both producers every cycle -> strict alternation starting with RS
    do_reset();
    src_log.delete();
    for (int i = 0; i < 6; i++) begin
      drive_rs(8'h10 + 8'(i), 32'h100 + 32'(i), 32'h1000 + 32'(i * 4), 1'b1);
      drive_lsb(8'h20 + 8'(i), 32'h200 + 32'(i), 1'b1);
      tick();
    end
    drain("drain_alt", 30);
    check("alt_count", 80'(src_log.size()), 80'd12);
    for (int k = 0; k < src_log.size() && k < 12; k++)
      check("alt_src", 80'(src_log[k]), 80'(k % 2));

    // 4: LSB fills while RS stays busy; full clears on an LSB grant
    do_reset();
    seen_full = 1'b0;
    done = 1'b0;
    rs_n = 0;
    lsb_n = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (seen_full && bus.CDB_en && bus.CDB_src) begin
        check("lsb_full_clear", 80'(bus.CDBLSB_full), 80'd0);
        done = 1'b1;
      end else begin
        if (bus.CDBLSB_full) seen_full = 1'b1;
        idle();
        if (!bus.CDBRS_full) begin
          drive_rs(8'h40 + 8'(rs_n), 32'h400 + 32'(rs_n), 32'h4000 + 32'(rs_n), 1'b1);
          rs_n++;
        end
        if (!bus.CDBLSB_full) begin
          drive_lsb(8'h60 + 8'(lsb_n), 32'h600 + 32'(lsb_n), 1'b1);
          lsb_n++;
        end
        tick();
      end
    end
    check("lsb_full_seen", 80'(seen_full), 80'd1);
    check("lsb_full_done", 80'(done), 80'd1);
    drain("drain_full", 40);

    // 5: mispredict flush discards queued results and the same-cycle push
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_rs(8'h80 + 8'(i), 32'h800 + 32'(i), 32'h8000 + 32'(i), 1'b1);
      drive_lsb(8'hA0 + 8'(i), 32'hA00 + 32'(i), 1'b1);
      tick();
    end
    idle();
    drive_rs(8'hEE, 32'hBAD, 32'hBAD0, 1'b0);
    RoBCDB_pre_judge = 1'b0;
    tick();
    rs_q.delete();
    lsb_q.delete();
    RoBCDB_pre_judge = 1'b1;
    idle();
    check("flush_cdb_en",   80'(bus.CDB_en), 80'd0);
    check("flush_rs_full",  80'(bus.CDBRS_full), 80'd0);
    check("flush_lsb_full", 80'(bus.CDBLSB_full), 80'd0);
    repeat (6) tick();
    drive_rs(8'h33, 32'h3333, 32'h330, 1'b1);
    tick();
    drain("drain_post_flush", 10);

    // 6: freeze with entries queued, then resume in order
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_rs(8'hC0 + 8'(i), 32'hC00 + 32'(i), 32'hC000 + 32'(i), 1'b1);
      drive_lsb(8'hD0 + 8'(i), 32'hD00 + 32'(i), 1'b1);
      tick();
    end
    Sys_rdy = 1'b0;
    drive_rs(8'hFE, 32'hF00D, 32'hF0, 1'b0);
    drive_lsb(8'hFD, 32'hF11D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_cdb_en", 80'(bus.CDB_en), 80'd0);
    end
    idle();
    Sys_rdy = 1'b1;
    drain("drain_freeze", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
